// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory responder for the pipelined CPU. One 2^ADDR_W x DATA_W
//            word array serves three CPU channels and a host preload port:
//              - instruction fetch read  (registered, 1-cycle latency)
//              - load-data read          (registered, 1-cycle latency)
//              - store write             (commits at the sampling edge)
//              - host preload write      (CPU store wins on conflict)
//            After every reset an internal clear sequencer zero-fills the
//            array. Fetches that occur before the first program write
//            therefore decode as NOOP.
//
// Ports    : clk, reset (async, active-high)
//            read_mem_ir / mem_radrs_ir  -> instr_rdata
//            read_mem_str / mem_radrs_LD -> load_rdata
//            write_mem / mem_wadrs / mem_wdata
//            host_we / host_adrs / host_wdata -> host_ack (1-cycle pulse)
//            mem_ready : high once the clear sequence has completed
//
// Options  : MEM_FWD_EN defined   -> write-first for same-edge reads
//            MEM_FWD_EN undefined -> read-first (old contents returned)
//
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_mem_ir,
    input  logic [ADDR_W-1:0] mem_radrs_ir,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              read_mem_str,
    input  logic [ADDR_W-1:0] mem_radrs_LD,
    output logic [DATA_W-1:0] load_rdata,
    input  logic              write_mem,
    input  logic [ADDR_W-1:0] mem_wadrs,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_adrs,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              mem_ready
);

    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic [DATA_W-1:0]   r_instr_rdata;
    logic [DATA_W-1:0]   r_load_rdata;
    logic                r_host_ack;

    // Single array write port, shared by the clear sequencer, CPU and host.
    logic                w_we;
    logic [ADDR_W-1:0]   w_wadr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_host_take;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_ir_data;
    logic [DATA_W-1:0]   w_ld_data;

    // ------------------------------------------------------------------------
    // State register and clear counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and write-port arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_wadr       = '0;
        w_wdata      = '0;
        w_host_take  = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_wadr = r_clr_cnt;
                // All-ones count is the last word of the array.
                if (&r_clr_cnt) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_rd_en = 1'b1;
                // CPU store has priority; a blocked host request is not
                // acknowledged and must be held until write_mem drops.
                if (write_mem) begin
                    w_we    = 1'b1;
                    w_wadr  = mem_wadrs;
                    w_wdata = mem_wdata;
                end else if (host_we) begin
                    w_we        = 1'b1;
                    w_wadr      = host_adrs;
                    w_wdata     = host_wdata;
                    w_host_take = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Array storage (contents are not reset; the clear sequence rewrites it)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wadr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read data selection
    // ------------------------------------------------------------------------
`ifdef MEM_FWD_EN
    // Write-first: the winning same-edge write bypasses the array.
    assign w_ir_data = (w_we && (w_wadr == mem_radrs_ir)) ? w_wdata : r_mem[mem_radrs_ir];
    assign w_ld_data = (w_we && (w_wadr == mem_radrs_LD)) ? w_wdata : r_mem[mem_radrs_LD];
`else
    // Read-first: old contents are returned for a same-edge same address.
    assign w_ir_data = r_mem[mem_radrs_ir];
    assign w_ld_data = r_mem[mem_radrs_LD];
`endif

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_rdata <= '0;
            r_load_rdata  <= '0;
            r_host_ack    <= 1'b0;
        end else begin
            if (w_rd_en && read_mem_ir) begin
                r_instr_rdata <= w_ir_data;
            end
            if (w_rd_en && read_mem_str) begin
                r_load_rdata <= w_ld_data;
            end
            r_host_ack <= w_host_take;
        end
    end

    assign instr_rdata = r_instr_rdata;
    assign load_rdata  = r_load_rdata;
    assign host_ack    = r_host_ack;
    // The state register flips to READY on the edge that writes the last word.
    assign mem_ready   = (r_state == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. A behavioural model
//            (plain array plus clear-progress counter) predicts every output
//            each cycle. Directed scenarios are followed by a randomized
//            phase over a small address window to provoke collisions.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_mem_ir = 1'b0;
    logic [AW-1:0] mem_radrs_ir = '0;
    logic [DW-1:0] instr_rdata;
    logic          read_mem_str = 1'b0;
    logic [AW-1:0] mem_radrs_LD = '0;
    logic [DW-1:0] load_rdata;
    logic          write_mem = 1'b0;
    logic [AW-1:0] mem_wadrs = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_adrs = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic          mem_ready;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .read_mem_ir  (read_mem_ir),
        .mem_radrs_ir (mem_radrs_ir),
        .instr_rdata  (instr_rdata),
        .read_mem_str (read_mem_str),
        .mem_radrs_LD (mem_radrs_LD),
        .load_rdata   (load_rdata),
        .write_mem    (write_mem),
        .mem_wadrs    (mem_wadrs),
        .mem_wdata    (mem_wdata),
        .host_we      (host_we),
        .host_adrs    (host_adrs),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr;
    bit            m_ready;
    logic [DW-1:0] exp_ir;
    logic [DW-1:0] exp_ld;
    bit            exp_ack;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // After reset the memory is observably all-zero once the clear finishes,
    // and nothing can be read or written before then.
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clr   = 0;
        m_ready = 1'b0;
        exp_ir  = '0;
        exp_ld  = '0;
        exp_ack = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        if (reset) return;
        if (!m_ready) begin
            m_clr++;
            if (m_clr == DEPTH) m_ready = 1'b1;
            exp_ack = 1'b0;
            return;
        end
        wv = write_mem || host_we;
        wa = write_mem ? mem_wadrs : host_adrs;
        wd = write_mem ? mem_wdata : host_wdata;
        if (read_mem_ir) begin
            rd = m_mem[mem_radrs_ir];
`ifdef MEM_FWD_EN
            if (wv && wa == mem_radrs_ir) rd = wd;
`endif
            exp_ir = rd;
        end
        if (read_mem_str) begin
            rd = m_mem[mem_radrs_LD];
`ifdef MEM_FWD_EN
            if (wv && wa == mem_radrs_LD) rd = wd;
`endif
            exp_ld = rd;
        end
        exp_ack = host_we && !write_mem;
        if (wv) m_mem[wa] = wd;
    endtask

    task automatic compare_all();
        check("instr_rdata", instr_rdata, exp_ir);
        check("load_rdata", load_rdata, exp_ld);
        check("host_ack", {31'd0, host_ack}, {31'd0, exp_ack});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, m_ready});
    endtask

    // Inputs change at posedge+1; outputs are compared at posedge+1.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    logic [DW-1:0] fwd_exp;

    initial begin
        model_reset();
        @(posedge clk);
        #1;

        // Reset clear with a fetch of the top word held throughout.
        read_mem_ir  = 1'b1;
        mem_radrs_ir = 11'h7FF;
        do_reset(3);
        repeat (DEPTH - 1) cycle();
        check("ready_before_last", {31'd0, mem_ready}, 32'd0);
        cycle();
        check("ready_at_last", {31'd0, mem_ready}, 32'd1);
        cycle();
        check("fetch_top_zero", instr_rdata, 32'h0);
        read_mem_ir = 1'b0;

        // Host preload then fetch.
        host_we = 1'b1; host_adrs = 11'h005; host_wdata = 32'h8000_1234;
        cycle();
        host_we = 1'b0;
        check("preload_ack", {31'd0, host_ack}, 32'd1);
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h005;
        cycle();
        check("preload_ack_drop", {31'd0, host_ack}, 32'd0);
        check("preload_fetch", instr_rdata, 32'h8000_1234);
        read_mem_ir = 1'b0;

        // CPU store / load.
        write_mem = 1'b1; mem_wadrs = 11'h010; mem_wdata = 32'hDEAD_BEEF;
        cycle();
        write_mem = 1'b0;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h010;
        cycle();
        check("store_load", load_rdata, 32'hDEAD_BEEF);
        read_mem_str = 1'b0;

        // Write conflict: CPU wins, host holds.
        write_mem = 1'b1; mem_wadrs = 11'h020; mem_wdata = 32'h1111_1111;
        host_we = 1'b1; host_adrs = 11'h021; host_wdata = 32'h2222_2222;
        cycle();
        check("conflict_no_ack", {31'd0, host_ack}, 32'd0);
        write_mem = 1'b0;
        cycle();
        check("conflict_ack", {31'd0, host_ack}, 32'd1);
        host_we = 1'b0;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h020;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h021;
        cycle();
        check("conflict_cpu_word", instr_rdata, 32'h1111_1111);
        check("conflict_host_word", load_rdata, 32'h2222_2222);
        read_mem_ir = 1'b0; read_mem_str = 1'b0;

        // Same-edge write and load to one address.
        write_mem = 1'b1; mem_wadrs = 11'h030; mem_wdata = 32'hAAAA_5555;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h030;
        cycle();
`ifdef MEM_FWD_EN
        fwd_exp = 32'hAAAA_5555;
`else
        fwd_exp = 32'h0000_0000;
`endif
        check("same_edge_load", load_rdata, fwd_exp);
        write_mem = 1'b0; read_mem_str = 1'b0;

        // Randomized traffic over a narrow window to force collisions.
        for (int i = 0; i < 600; i++) begin
            read_mem_ir  = 1'($urandom);
            mem_radrs_ir = AW'($urandom_range(0, 15));
            read_mem_str = 1'($urandom);
            mem_radrs_LD = AW'($urandom_range(0, 15));
            write_mem    = ($urandom_range(0, 2) == 0);
            mem_wadrs    = AW'($urandom_range(0, 15));
            mem_wdata    = $urandom;
            host_we      = ($urandom_range(0, 2) == 0);
            host_adrs    = AW'($urandom_range(0, 15));
            host_wdata   = $urandom;
            cycle();
        end
        read_mem_ir = 1'b0; read_mem_str = 1'b0; write_mem = 1'b0; host_we = 1'b0;

        // Mid-clear reset, with host writes attempted during both clears.
        do_reset(2);
        for (int i = 0; i < 100; i++) begin
            host_we = (i >= 10 && i < 50); host_adrs = 11'h040; host_wdata = 32'hCAFE_0000;
            cycle();
        end
        host_we = 1'b0;
        do_reset(2);
        for (int i = 0; i < DEPTH - 1; i++) begin
            host_we = (i < 20); host_adrs = 11'h041; host_wdata = 32'hCAFE_0001;
            write_mem = (i < 5); mem_wadrs = 11'h042; mem_wdata = 32'h1234_5678;
            cycle();
        end
        host_we = 1'b0; write_mem = 1'b0;
        check("midclear_not_ready", {31'd0, mem_ready}, 32'd0);
        cycle();
        check("midclear_ready", {31'd0, mem_ready}, 32'd1);
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h040;
        read_mem_str = 1'b1; mem_radrs_LD = 11'h041;
        cycle();
        check("clear_drop_host40", instr_rdata, 32'h0);
        check("clear_drop_host41", load_rdata, 32'h0);
        mem_radrs_ir = 11'h042;
        cycle();
        check("clear_drop_cpu42", instr_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
